field_loader: RTL and testbench

- Initial-pattern loader between the combinational field ROM (upstream) and the writable field memory of the life engine (downstream).
- On a start pulse it raster-scans every cell address and drives it to the ROM.
- It registers each returned cell state and presents it as a write beat with a valid/ready handshake.
- Done is signalled once the last cell has been accepted.

---
 rtl/field_loader.sv | 161 ++++++++++++++++
 tb/tb_field_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/field_loader.sv
// field_loader
//   Copies the initial cell pattern from the combinational field ROM into the
//   life engine's field memory.
//
//   A start pulse in IDLE begins the load. Every cell is addressed in raster
//   order (y outer, x inner) and the ROM answer is registered into a
//   one-entry write buffer. That buffer is presented downstream with a
//   valid/ready handshake. After the last beat is accepted, o_done pulses
//   for one cycle.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_start          start a load (sampled in IDLE only)
//   o_busy           high from start acceptance until the final handshake
//   o_done           one-cycle pulse after the final handshake
//   o_rom_x_adr      ROM cell x address (scan counter)
//   o_rom_y_adr      ROM cell y address (scan counter)
//   i_rom_cell_state ROM data for the current address
//   o_wr_valid       write beat present
//   i_wr_ready       downstream accepts the beat this cycle
//   o_wr_x, o_wr_y   write cell address
//   o_wr_data        write cell state
module field_loader #(
  parameter int FIELD_W = 4,
  parameter int FIELD_H = 3,
  localparam int X_ADR_SIZE = (FIELD_W > 1) ? $clog2(FIELD_W) : 1,
  localparam int Y_ADR_SIZE = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [X_ADR_SIZE-1:0] o_rom_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rom_y_adr,
  input  logic                  i_rom_cell_state,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  output logic [X_ADR_SIZE-1:0] o_wr_x,
  output logic [Y_ADR_SIZE-1:0] o_wr_y,
  output logic                  o_wr_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [X_ADR_SIZE-1:0]   x_cnt;
  logic [Y_ADR_SIZE-1:0]   y_cnt;
  logic                    start_accept;
  logic                    advance;
  logic                    last_cell;
  logic                    drain_ack;

  // The output register may be refilled when it is empty or being emptied
  // in this same cycle, which gives one beat per cycle under full ready.
  assign start_accept = (state == IDLE) && i_start;
  assign advance      = (state == LOAD) && (!o_wr_valid || i_wr_ready);
  assign last_cell    = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign drain_ack    = (state == DRAIN) && o_wr_valid && i_wr_ready;

  assign o_rom_x_adr  = x_cnt;
  assign o_rom_y_adr  = y_cnt;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (advance && last_cell) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = LOAD;
        end
      end
      DRAIN: begin
        if (drain_ack) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Scan counters, write buffer and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_x     <= '0;
      o_wr_y     <= '0;
      o_wr_data  <= 1'b0;
    end else begin
      o_done <= 1'b0;

      if (start_accept) begin
        x_cnt  <= '0;
        y_cnt  <= '0;
        o_busy <= 1'b1;
      end

      if (advance) begin
        o_wr_x     <= x_cnt;
        o_wr_y     <= y_cnt;
        o_wr_data  <= i_rom_cell_state;
        o_wr_valid <= 1'b1;
        // Explicit wrap compares keep non-power-of-two fields in range;
        // the final cell returns both counters to the origin.
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          if (y_cnt == Y_LAST) begin
            y_cnt <= '0;
          end else begin
            y_cnt <= y_cnt + Y_ADR_SIZE'(1);
          end
        end else begin
          x_cnt <= x_cnt + X_ADR_SIZE'(1);
        end
      end else if (o_wr_valid && i_wr_ready) begin
        o_wr_valid <= 1'b0;
      end

      if (drain_ack) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_field_loader.sv
// Self-checking bench for field_loader. Three instances (4x3, 1x1, 5x3)
// share one ROM image; a selector routes start to one of them and
// multiplexes its outputs onto a common set of observation signals.
module tb_field_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  int   sel;
  logic rom_mem [0:31];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // 4x3 instance
  logic       a_start, a_busy, a_done, a_cell, a_valid, a_data;
  logic [1:0] a_rx, a_x;
  logic [1:0] a_ry, a_y;
  // 1x1 instance
  logic       b_start, b_busy, b_done, b_cell, b_valid, b_data;
  logic [0:0] b_rx, b_x;
  logic [0:0] b_ry, b_y;
  // 5x3 instance
  logic       c_start, c_busy, c_done, c_cell, c_valid, c_data;
  logic [2:0] c_rx, c_x;
  logic [1:0] c_ry, c_y;

  assign a_start = start && (sel == 0);
  assign b_start = start && (sel == 1);
  assign c_start = start && (sel == 2);

  // ROM image laid out in raster order: cell (x,y) lives at y*W + x.
  assign a_cell = rom_mem[4 * int'(a_ry) + int'(a_rx)];
  assign b_cell = rom_mem[int'(b_ry) + int'(b_rx)];
  assign c_cell = rom_mem[5 * int'(c_ry) + int'(c_rx)];

  field_loader #(.FIELD_W(4), .FIELD_H(3)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
    .o_rom_x_adr(a_rx), .o_rom_y_adr(a_ry), .i_rom_cell_state(a_cell),
    .o_wr_valid(a_valid), .i_wr_ready(ready), .o_wr_x(a_x), .o_wr_y(a_y), .o_wr_data(a_data)
  );

  field_loader #(.FIELD_W(1), .FIELD_H(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .o_rom_x_adr(b_rx), .o_rom_y_adr(b_ry), .i_rom_cell_state(b_cell),
    .o_wr_valid(b_valid), .i_wr_ready(ready), .o_wr_x(b_x), .o_wr_y(b_y), .o_wr_data(b_data)
  );

  field_loader #(.FIELD_W(5), .FIELD_H(3)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(c_start), .o_busy(c_busy), .o_done(c_done),
    .o_rom_x_adr(c_rx), .o_rom_y_adr(c_ry), .i_rom_cell_state(c_cell),
    .o_wr_valid(c_valid), .i_wr_ready(ready), .o_wr_x(c_x), .o_wr_y(c_y), .o_wr_data(c_data)
  );

  logic        mon_busy, mon_done, mon_valid, mon_data;
  logic [31:0] mon_x, mon_y, mon_rx, mon_ry;

  // Route the selected instance onto the observation signals.
  always_comb begin
    mon_busy  = 1'b0;
    mon_done  = 1'b0;
    mon_valid = 1'b0;
    mon_data  = 1'b0;
    mon_x     = 32'd0;
    mon_y     = 32'd0;
    mon_rx    = 32'd0;
    mon_ry    = 32'd0;
    case (sel)
      0: begin
        mon_busy = a_busy; mon_done = a_done; mon_valid = a_valid; mon_data = a_data;
        mon_x = 32'(a_x); mon_y = 32'(a_y); mon_rx = 32'(a_rx); mon_ry = 32'(a_ry);
      end
      1: begin
        mon_busy = b_busy; mon_done = b_done; mon_valid = b_valid; mon_data = b_data;
        mon_x = 32'(b_x); mon_y = 32'(b_y); mon_rx = 32'(b_rx); mon_ry = 32'(b_ry);
      end
      default: begin
        mon_busy = c_busy; mon_done = c_done; mon_valid = c_valid; mon_data = c_data;
        mon_x = 32'(c_x); mon_y = 32'(c_y); mon_rx = 32'(c_rx); mon_ry = 32'(c_ry);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic rand_rom();
    for (int i = 0; i < 32; i++) rom_mem[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {28'd0, mon_busy, mon_done, mon_valid, mon_data}, 32'd0);
    check({tag, "_addrs"}, mon_x | mon_y | mon_rx | mon_ry, 32'd0);
  endtask

  // One load on the selected instance.
  //   mode 0: ready always 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready
  //   restart_at: pulse start again once that many beats have been accepted
  //   reset_at:   assert reset once that many beats have been accepted
  //   chain:      assert start in the done cycle and return immediately
  task automatic run_load(input int mode, input bit do_start, input int restart_at,
                          input int reset_at, input bit chain);
    int fw, fh, n, idx, cyc, tail;
    bit fin, held, restarted, seen_done;
    logic r;
    logic [31:0] hx, hy;
    logic hd;
    int ex [0:31];
    int ey [0:31];
    logic ed [0:31];
    fw = (sel == 0) ? 4 : (sel == 1) ? 1 : 5;
    fh = (sel == 0) ? 3 : (sel == 1) ? 1 : 3;
    n = fw * fh;
    for (int i = 0; i < n; i++) begin
      ex[i] = i % fw;
      ey[i] = i / fw;
      ed[i] = rom_mem[i];
    end
    idx = 0; cyc = -1; tail = 0;
    fin = 1'b0; held = 1'b0; restarted = 1'b0; seen_done = 1'b0;
    hx = 32'd0; hy = 32'd0; hd = 1'b0;
    if (do_start) start = 1'b1;
    while (!fin && cyc < 400) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (reset_at >= 0 && idx == reset_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
          @(posedge clk); #1;
          check("post_rst_quiet", {29'd0, mon_busy, mon_done, mon_valid}, 32'd0);
        end
        return;
      end
      if (cyc == 0) begin
        check("busy_rise", 32'(mon_busy), 32'd1);
        check("done_low_at_start", 32'(mon_done), 32'd0);
      end
      if (mon_done) begin
        check("done_once", 32'(seen_done), 32'd0);
        seen_done = 1'b1;
        check("done_beats", idx, n);
        check("done_busy", 32'(mon_busy), 32'd0);
        check("done_valid", 32'(mon_valid), 32'd0);
        if (mode == 0) check("done_latency", cyc, n + 1);
        if (chain) begin
          start = 1'b1;
          fin = 1'b1;
        end
        continue;
      end
      if (seen_done) begin
        check("after_done", {29'd0, mon_busy, mon_done, mon_valid}, 32'd0);
        tail++;
        if (tail == 2) fin = 1'b1;
        continue;
      end
      if (mon_valid) begin
        check("valid_busy", 32'(mon_busy), 32'd1);
        if (mode == 0 && idx == 0) check("first_beat_cycle", cyc, 1);
        if (held) begin
          check("stall_hold_x", mon_x, hx);
          check("stall_hold_y", mon_y, hy);
          check("stall_hold_data", 32'(mon_data), 32'(hd));
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready = r;
      if (mon_valid && r) begin
        if (idx < n) begin
          check("beat_x", mon_x, ex[idx]);
          check("beat_y", mon_y, ey[idx]);
          check("beat_data", 32'(mon_data), 32'(ed[idx]));
        end else begin
          check("extra_beat", idx, n - 1);
        end
        idx++;
        held = 1'b0;
      end else if (mon_valid) begin
        held = 1'b1;
        hx = mon_x; hy = mon_y; hd = mon_data;
      end else begin
        held = 1'b0;
      end
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
    end
    check("load_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    sel = 0;
    rand_rom();
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_reset_outputs("reset_state");
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x3: full ready, stall pattern, random ready with ignored restart
    rand_rom(); run_load(0, 1'b1, -1, -1, 1'b0);
    rand_rom(); run_load(1, 1'b1, -1, -1, 1'b0);
    rand_rom(); run_load(2, 1'b1, 5, -1, 1'b0);
    // reset mid-load, then a fresh full load
    rand_rom(); run_load(0, 1'b1, -1, 6, 1'b0);
    rand_rom(); run_load(1, 1'b1, -1, -1, 1'b0);
    // restart in the done cycle
    rand_rom(); run_load(0, 1'b1, -1, -1, 1'b1);
    run_load(2, 1'b0, -1, -1, 1'b0);

    // 1x1 field
    sel = 1;
    rand_rom(); run_load(0, 1'b1, -1, -1, 1'b0);
    rand_rom(); run_load(2, 1'b1, -1, -1, 1'b0);

    // 5x3 field
    sel = 2;
    rand_rom(); run_load(0, 1'b1, -1, -1, 1'b0);
    rand_rom(); run_load(2, 1'b1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
